// File: rtl/ftoi_unit.sv
// rtl/ftoi_unit.sv - registered float32 to int32 converter, round half away from zero
module ftoi_unit (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   input  logic [31:0] x,
   output logic        out_valid,
   output logic [31:0] y,
   output logic        exception
);

   logic        sgn;
   logic [7:0]  e;
   logic [22:0] m;
   logic [23:0] sig;
   logic [7:0]  rdist;
   logic [7:0]  ldist;
   logic [24:0] rshifted;
   logic [31:0] mag;
   logic [31:0] y_next;
   logic        exc_next;

   assign sgn   = x[31];
   assign e     = x[30:23];
   assign m     = x[22:0];
   assign sig   = {1'b1, m};
   assign rdist = 8'd150 - e;
   assign ldist = e - 8'd150;

   // Shift a guard bit along with the significand so bit 0 is the first dropped bit.
   assign rshifted = {sig, 1'b0} >> rdist[4:0];

   always_comb begin
      mag = 32'd0;
      if (e <= 8'd125)
         mag = 32'd0;
      else if (e == 8'd126)
         mag = 32'd1;
      else if (e <= 8'd150)
         mag = {8'd0, rshifted[24:1]} + {31'd0, rshifted[0]};
      else
         mag = {8'd0, sig} << ldist[2:0];
   end

   always_comb begin
      y_next   = 32'd0;
      exc_next = 1'b0;
      if (e == 8'd255) begin
         exc_next = 1'b1;
         y_next   = (m != 23'd0 || !sgn) ? 32'h7fff_ffff : 32'h8000_0000;
      end else if (e >= 8'd158) begin
         // -2^31 is the one value at this magnitude that int32 can hold.
         if (sgn && e == 8'd158 && m == 23'd0) begin
            y_next = 32'h8000_0000;
         end else begin
            exc_next = 1'b1;
            y_next   = sgn ? 32'h8000_0000 : 32'h7fff_ffff;
         end
      end else if (e != 8'd0) begin
         y_next = sgn ? (32'd0 - mag) : mag;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         y         <= 32'd0;
         exception <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            y         <= y_next;
            exception <= exc_next;
         end
      end
   end

endmodule

// File: tb/tb_ftoi_unit.sv
// tb/tb_ftoi_unit.sv - randomized bench for ftoi_unit against a real-arithmetic model
module tb_ftoi_unit;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic [31:0] x;
   logic        out_valid;
   logic [31:0] y;
   logic        exception;

   int n_checks;
   int n_pass;

   logic        prev_in;
   logic [31:0] exp_y;
   logic        exp_exc;

   ftoi_unit dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .x         (x),
      .out_valid (out_valid),
      .y         (y),
      .exception (exception)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want)
         n_pass++;
      else
         $display("FAIL %s: got %08h expected %08h", tag, got, want);
   endtask

   // Reference: evaluate the float exactly as a real, round half away from zero, then range-check.
   task automatic ref_model(input logic [31:0] v, output logic [31:0] ry, output logic rexc);
      int  ev;
      real mag;
      real r;
      longint li;
      ev = int'(v[30:23]);
      rexc = 1'b0;
      ry = 32'd0;
      if (ev == 255) begin
         rexc = 1'b1;
         ry = (v[22:0] != 0 || !v[31]) ? 32'h7fff_ffff : 32'h8000_0000;
      end else if (ev != 0) begin
         mag = (1.0 + real'(v[22:0]) / 8388608.0) * (2.0 ** (ev - 127));
         r = $floor(mag + 0.5);
         if (!v[31]) begin
            if (r > 2147483647.0) begin
               rexc = 1'b1;
               ry = 32'h7fff_ffff;
            end else begin
               li = longint'(r);
               ry = li[31:0];
            end
         end else begin
            if (r > 2147483648.0) begin
               rexc = 1'b1;
               ry = 32'h8000_0000;
            end else begin
               li = -longint'(r);
               ry = li[31:0];
            end
         end
      end
   endtask

   // One negedge: check what the last edge registered, then present the next input.
   task automatic step(input logic v, input logic [31:0] xv, input logic [31:0] ey, input logic eexc);
      @(negedge clk);
      check("out_valid", {31'd0, out_valid}, {31'd0, prev_in});
      check("y", y, exp_y);
      check("exception", {31'd0, exception}, {31'd0, exp_exc});
      in_valid = v;
      x = xv;
      prev_in = v;
      if (v) begin
         exp_y = ey;
         exp_exc = eexc;
      end
   endtask

   task automatic step_model(input logic v, input logic [31:0] xv);
      logic [31:0] ry;
      logic        rexc;
      ref_model(xv, ry, rexc);
      step(v, xv, ry, rexc);
   endtask

   logic [31:0] dir_x   [0:19];
   logic [31:0] dir_y   [0:19];
   logic        dir_exc [0:19];

   initial begin
      logic [22:0] pats [0:6];
      logic [22:0] mk;
      logic [22:0] keep;
      int          k;
      n_checks = 0;
      n_pass = 0;
      dir_x[0]  = 32'h3F000000; dir_y[0]  = 32'h00000001; dir_exc[0]  = 1'b0;
      dir_x[1]  = 32'h3FC00000; dir_y[1]  = 32'h00000002; dir_exc[1]  = 1'b0;
      dir_x[2]  = 32'h40200000; dir_y[2]  = 32'h00000003; dir_exc[2]  = 1'b0;
      dir_x[3]  = 32'hBFC00000; dir_y[3]  = 32'hFFFFFFFE; dir_exc[3]  = 1'b0;
      dir_x[4]  = 32'h3EFFFFFF; dir_y[4]  = 32'h00000000; dir_exc[4]  = 1'b0;
      dir_x[5]  = 32'h3F800000; dir_y[5]  = 32'h00000001; dir_exc[5]  = 1'b0;
      dir_x[6]  = 32'h4B7FFFFF; dir_y[6]  = 32'h00FFFFFF; dir_exc[6]  = 1'b0;
      dir_x[7]  = 32'h4EFFFFFF; dir_y[7]  = 32'h7FFFFF80; dir_exc[7]  = 1'b0;
      dir_x[8]  = 32'hCF000000; dir_y[8]  = 32'h80000000; dir_exc[8]  = 1'b0;
      dir_x[9]  = 32'h4F000000; dir_y[9]  = 32'h7FFFFFFF; dir_exc[9]  = 1'b1;
      dir_x[10] = 32'hCF000001; dir_y[10] = 32'h80000000; dir_exc[10] = 1'b1;
      dir_x[11] = 32'h7F800000; dir_y[11] = 32'h7FFFFFFF; dir_exc[11] = 1'b1;
      dir_x[12] = 32'hFF800000; dir_y[12] = 32'h80000000; dir_exc[12] = 1'b1;
      dir_x[13] = 32'h7FC00000; dir_y[13] = 32'h7FFFFFFF; dir_exc[13] = 1'b1;
      dir_x[14] = 32'hFFC00001; dir_y[14] = 32'h7FFFFFFF; dir_exc[14] = 1'b1;
      dir_x[15] = 32'h00000000; dir_y[15] = 32'h00000000; dir_exc[15] = 1'b0;
      dir_x[16] = 32'h80000000; dir_y[16] = 32'h00000000; dir_exc[16] = 1'b0;
      dir_x[17] = 32'h00000001; dir_y[17] = 32'h00000000; dir_exc[17] = 1'b0;
      dir_x[18] = 32'h40600000; dir_y[18] = 32'h00000004; dir_exc[18] = 1'b0;
      dir_x[19] = 32'hC0200000; dir_y[19] = 32'hFFFFFFFD; dir_exc[19] = 1'b0;
      pats[0] = 23'h000000; pats[1] = 23'h000001; pats[2] = 23'h000002;
      pats[3] = 23'h380000; pats[4] = 23'h400000; pats[5] = 23'h5FFFFF;
      pats[6] = 23'h7FFFFF;

      rstn = 1'b0;
      in_valid = 1'b0;
      x = 32'd0;
      prev_in = 1'b0;
      exp_y = 32'd0;
      exp_exc = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_y", y, 32'd0);
      check("reset_exc", {31'd0, exception}, 32'd0);
      check("reset_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Directed table, back to back, then a bubble to show the hold.
      for (int i = 0; i < 20; i++)
         step(1'b1, dir_x[i], dir_y[i], dir_exc[i]);
      step(1'b0, 32'h4F000000, 32'd0, 1'b0);
      step(1'b0, 32'h3F800000, 32'd0, 1'b0);

      // Exponent/sign/mantissa sweep with random bubbles and rounding-boundary pairs.
      for (int ev = 0; ev < 256; ev++) begin
         for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 9; p++) begin
               if (p < 7)
                  mk = pats[p];
               else if (p == 7)
                  mk = 23'($urandom);
               else begin
                  k = int'($urandom_range(0, 22));
                  keep = 23'h7FFFFF << k;
                  mk = (mk & keep) | (23'($urandom) & ~keep);
               end
               step_model(($urandom_range(0, 7) != 0), {s[0], ev[7:0], mk});
            end
         end
      end

      // Five back-to-back valids, then asynchronous reset between edges.
      for (int i = 0; i < 5; i++)
         step_model(1'b1, $urandom);
      #2;
      rstn = 1'b0;
      #1;
      check("async_rst_y", y, 32'd0);
      check("async_rst_exc", {31'd0, exception}, 32'd0);
      check("async_rst_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
      check("rst_hold_y", y, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      prev_in = 1'b0;
      exp_y = 32'd0;
      exp_exc = 1'b0;
      rstn = 1'b1;
      step(1'b0, 32'h3F800000, 32'd0, 1'b0);
      step(1'b1, 32'h4F000000, 32'h7FFFFFFF, 1'b1);
      for (int i = 0; i < 40; i++)
         step_model(($urandom_range(0, 3) != 0), $urandom);
      step(1'b0, 32'd0, 32'd0, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ftoi_unit.md
# ftoi_unit

Registered IEEE-754 single-precision to signed 32-bit integer converter for the FPU datapath. Accepts one float per clock and produces the round-to-nearest (ties away from zero) two's-complement integer one cycle later. Out-of-range, infinite and NaN inputs saturate and raise an exception flag. Fully pipelined with no stalls.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  x is valid this cycle.
- x  in  32  float operand: x[31] sign, x[30:23] biased exponent e, x[22:0] fraction m.
- out_valid  out  1  y/exception valid; in_valid delayed by one cycle.
- y  out  32  signed integer result, two's complement.
- exception  out  1  input was NaN, ±inf, or out of int32 range.

## Operation
- Magnitude value: v = 1.m × 2^(e−127) for 1 ≤ e ≤ 254. e = 0 (zero/denormal): result 0, no exception.
- Rounding: round to nearest integer, ties away from zero, applied to the magnitude before sign application.
  - e ≤ 125 (|v| < 0.5): result 0.
  - e = 126 (0.5 ≤ |v| < 1): magnitude 1.
  - 127 ≤ e ≤ 150: shift significand {1,m} right by 150−e; increment if the most significant dropped bit is 1.
  - 151 ≤ e ≤ 157: shift significand left by e−150; exact, no rounding.
- Sign: if x[31] = 1, y = −magnitude (two's complement), else y = magnitude. −0 gives 0.
- Range:
  - e = 158, x[31] = 1, m = 0 (exactly −2^31): y = 0x80000000, exception = 0.
  - Any other e ≥ 158 with e ≠ 255: saturate, exception = 1. Positive gives 0x7FFFFFFF; negative gives 0x80000000.
  - e = 255, m = 0 (±inf): saturate by sign as above, exception = 1.
  - e = 255, m ≠ 0 (NaN): y = 0x7FFFFFFF regardless of sign, exception = 1.
- Rounding never overflows, because every float with e ≥ 150 is already an integer.
- The datapath is purely combinational into one register stage. y and exception are captured every cycle in which in_valid = 1. When in_valid = 0 they hold their previous value.

## Timing
- Latency: 1 cycle.
  - out_valid(t+1) = in_valid(t).
  - y(t+1) and exception(t+1) are the result for x(t) whenever in_valid(t) = 1.
- Throughput: 1 conversion per cycle. There is no ready/backpressure signal.
- Reset (rstn low, asynchronous): y = 0, exception = 0, out_valid = 0 immediately, and they stay so while rstn is low.
- Deassertion of rstn is synchronised by the surrounding design. The first capture happens on the first rising edge with rstn high.
- Reset during streaming discards the in-flight result. out_valid stays 0 until a new in_valid has been registered.

## Test plan
- Rounding ties, each with exception = 0:
  - 0x3F000000 (0.5) -> 0x00000001
  - 0x3FC00000 (1.5) -> 0x00000002
  - 0x40200000 (2.5) -> 0x00000003
  - 0xBFC00000 (−1.5) -> 0xFFFFFFFE
  - 0x3EFFFFFF (<0.5) -> 0x00000000
- Exact and large values:
  - 0x3F800000 -> 1
  - 0x4B7FFFFF -> 0x00FFFFFF
  - 0x4EFFFFFF -> 0x7FFFFF80
  - 0xCF000000 -> 0x80000000 with exception = 0
- Saturation, each with exception = 1:
  - 0x4F000000 -> 0x7FFFFFFF
  - 0xCF000001 -> 0x80000000
  - 0x7F800000 -> 0x7FFFFFFF
  - 0xFF800000 -> 0x80000000
  - 0x7FC00000 and 0xFFC00001 -> 0x7FFFFFFF
- Zeros and denormals: 0x00000000, 0x80000000 and 0x00000001 -> 0 with exception = 0.
- Sweep: all 256 exponents × both signs × mantissa patterns (0, 1, 2, 0x380000, 0x400000, 0x5FFFFF, 0x7FFFFF, random).
  - Compare against a reference model of the rules above, exactly, one cycle later.
  - Pair a random x1 with an x2 sharing the upper mantissa bits, to stress the rounding boundary at every bit position.
- Reset/handshake:
  - Stream 5 valid inputs back-to-back: out_valid must follow in_valid by exactly 1 cycle, with no bubbles.
  - Assert rstn low mid-stream: y, exception and out_valid must drop to 0 without waiting for a clock edge.
  - When in_valid = 0: y must hold its previous value.
